// File: rtl/uart_tx_pkg.sv
// Shared constants and FSM state encoding for the uart_tx block.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam logic        IDLE_LEVEL           = 1'b1;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned CNT_W                = 16;
    localparam int unsigned BIT_CNT_W            = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO ahead of the shifter. Pointers carry one extra wrap bit.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the empty pointers mask stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter, 8N1 by default; define UART_TX_PARITY_EN
// for 8E1 frames with an even-parity bit between data and stop.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_CNT_W-1:0]   bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif
    logic                   bit_end;
    logic                   push_c;
    logic                   pop_c;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign in_ready = !rst && !fifo_full;
    assign push_c   = in_valid && in_ready;
    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .din   (in_data),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next state; tx_d mirrors the current state so the line lags it by one edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = IDLE_LEVEL;
        pop_c   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                tx_d = IDLE_LEVEL;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_dout;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^fifo_dout;
`endif
                end
            end
            ST_START: begin
                tx_d = ~IDLE_LEVEL;
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BIT_CNT_W'(1);
                    if (bit_q == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = par_q;
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                tx_d = IDLE_LEVEL;
                if (bit_end) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: accepted bytes are queued, and a mid-bit
// line sampler decodes frames and checks them against the queue.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    logic [7:0] exp_q[$];

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Compare one decoded frame against the oldest accepted byte.
    task automatic frame_done(input logic [NB-1:0] fb);
        logic [7:0] got;
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) got[i] = fb[1 + i];
        check("start bit", int'(fb[0]), 0);
        check("stop bit", int'(fb[NB-1]), 1);
        check("frame expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("frame data", int'(got), int'(exp));
`ifdef UART_TX_PARITY_EN
            check("parity bit", int'(fb[9]), int'($countones(exp) % 2));
`endif
        end
    endtask

    // Line sampler: phase counts cycles since the start edge, sample at mid-bit.
    initial begin
        int phase;
        logic [NB-1:0] fb;
        phase = -1;
        fb    = '0;
        forever begin
            @(negedge clk);
            if (rst) phase = -1;
            else if (phase < 0) begin
                if (tx == 1'b0) phase = 0;
            end else phase = phase + 1;
            if (phase >= 0 && (phase % CPB) == CPB / 2) begin
                fb[phase / CPB] = tx;
                if (phase / CPB == NB - 1) begin
                    frame_done(fb);
                    phase = -1;
                end
            end
        end
    end

    // Offer a byte until accepted; returns stall cycles and acceptance cycle.
    task automatic push(input logic [7:0] b, output int stalls, output int acc_cyc);
        logic rdy;
        int   n;
        rdy      = 1'b0;
        n        = 0;
        stalls   = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!rdy && n < 3000) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (!rdy) stalls++;
            n++;
        end
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
        check("push accepted", int'(rdy), 1);
        if (rdy) exp_q.push_back(b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain in time", int'(n < 5000), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int st, ac, ac0, n, first_stall, viol;
        logic [7:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tx", int'(tx), 1);
        check("reset busy", int'(busy), 0);
        check("reset in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready after reset", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Single byte: latency, frame length, busy fall
        push(8'hA5, st, ac0);
        check("busy after accept", int'(busy), 1);
        @(posedge clk);
        #1;
        check("tx high at N+1", int'(tx), 1);
        @(posedge clk);
        #1;
        check("tx low at N+2", int'(tx), 0);
        check("start latency", cyc - ac0, 2);
        n = 0;
        while (busy && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy fall cycle", cyc - ac0, 1 + NB * CPB);
        wait_idle();

        // Loopback patterns, plus parity cases
        push(8'h00, st, ac);
        push(8'hFF, st, ac);
        push(8'h3C, st, ac);
`ifdef UART_TX_PARITY_EN
        push(8'h07, st, ac);
        push(8'h03, st, ac);
`endif
        wait_idle();

        // Back-pressure and push-while-full across the pop cycle
        first_stall = -1;
        ac0 = 0;
        for (int i = 0; i < 6; i++) begin
            push(8'(i + 1), st, ac);
            if (i == 0) ac0 = ac;
            if (st > 0 && first_stall < 0) first_stall = i;
        end
        check("accepts before stall", first_stall, 5);
        check("held byte accept cycle", ac - ac0, 3 + NB * CPB);
        wait_idle();

        // Randomized traffic with random gaps
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            push(b, st, ac);
            repeat ($urandom_range(0, 50)) @(posedge clk);
            #1;
        end
        wait_idle();

        // Reset during DATA bit 3
        push(8'hFF, st, ac0);
        push(8'h55, st, ac);
        while (cyc < ac0 + 19) @(posedge clk);
        #1;
        check("busy before abort", int'(busy), 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("tx after abort", int'(tx), 1);
        check("busy after abort", int'(busy), 0);
        check("in_ready in reset", int'(in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready after abort", int'(in_ready), 1);
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        check("quiet after abort", viol, 0);

        check("leftover expected bytes", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
